// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regfile_arb_pkg;

  // Match RegAddrBus / RegBus widths from defines.v
  localparam int REG_ADDR_W   = 5;
  localparam int REG_DATA_W   = 32;
  localparam int ZERO_REG     = 0;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_P    = 2'd1,
    GNT_M    = 2'd2
  } gnt_e;

endpackage

// File: rtl/regfile_arb_starve.sv
// Saturating starvation counter for the M requester; raises force_m once M
// has waited STARVE_LIM cycles.
module regfile_arb_starve
  import regfile_arb_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic m_valid,
  input  logic m_ready,
  output logic force_m
);

  localparam logic [STARVE_CNT_W-1:0] LIM     = STARVE_CNT_W'(STARVE_LIM);
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

  logic [STARVE_CNT_W-1:0] count;

  // Clears whenever M is idle or served, otherwise counts up and sticks at max
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (!m_valid || m_ready) begin
      count <= '0;
    end else if (count != CNT_MAX) begin
      count <= count + 4'd1;
    end
  end

  assign force_m = m_valid && (count >= LIM);

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the single regfile write port (P = writeback, M = multi-cycle unit).
// Define REGFILE_ARB_FAIR_EN to compile in the M starvation counter; otherwise P has strict priority.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int DATA_W     = REG_DATA_W,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_valid,
  output logic              p_ready,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_waddr,
  input  logic [DATA_W-1:0] m_wdata,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [1:0]        gnt
);

  logic              force_m;
  gnt_e              gnt_q;
  gnt_e              win_gnt;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;

`ifdef REGFILE_ARB_FAIR_EN
  regfile_arb_starve #(
    .STARVE_LIM (STARVE_LIM)
  ) u_starve (
    .clk     (clk),
    .rst     (rst),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .force_m (force_m)
  );
`else
  assign force_m = 1'b0;
`endif

  always_comb begin
    p_ready = 1'b0;
    m_ready = 1'b0;
    if (!rst) begin
      p_ready = !force_m;
      m_ready = force_m || !p_valid;
    end
  end

  // Readies are mutually exclusive when both valid, so at most one winner
  always_comb begin
    win_gnt  = GNT_NONE;
    win_addr = p_waddr;
    win_data = p_wdata;
    if (p_valid && p_ready) begin
      win_gnt = GNT_P;
    end else if (m_valid && m_ready) begin
      win_gnt  = GNT_M;
      win_addr = m_waddr;
      win_data = m_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we    <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      gnt_q <= GNT_NONE;
    end else begin
      gnt_q <= win_gnt;
      we    <= 1'b0;
      if (win_gnt != GNT_NONE && win_addr != ADDR_W'(ZERO_REG)) begin
        we    <= 1'b1;
        waddr <= win_addr;
        wdata <= win_data;
      end
    end
  end

  assign gnt = gnt_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized scoreboard bench for regfile_wr_arbiter; follows REGFILE_ARB_FAIR_EN when defined.
module tb_regfile_wr_arbiter;

  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int LIM = 4;
`ifdef REGFILE_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          p_valid, m_valid;
  logic          p_ready, m_ready;
  logic [AW-1:0] p_waddr, m_waddr;
  logic [DW-1:0] p_wdata, m_wdata;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [1:0]    gnt;

  regfile_wr_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .STARVE_LIM (LIM)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .p_valid (p_valid),
    .p_ready (p_ready),
    .p_waddr (p_waddr),
    .p_wdata (p_wdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_waddr (m_waddr),
    .m_wdata (m_wdata),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .gnt     (gnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  gnt;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  bit          mon_en = 1'b0;

  bit          p_pend = 1'b0, m_pend = 1'b0, p_keep = 1'b0, rand_en = 1'b0;
  logic [4:0]  p_a = '0, m_a = '0;
  logic [31:0] p_d = '0, m_d = '0;
  int          m_wait = 0;
  bit          last_m_win;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of producers plus the reference model of who gets accepted
  task automatic applyStimulus(input bit do_rst);
    bit pr, mr, starved, p_win, m_win;
    @(posedge clk);
    #1;
    if (rand_en) begin
      if (!p_pend && $urandom_range(0, 99) < 55) begin
        p_pend = 1'b1; p_a = 5'($urandom_range(0, 31)); p_d = $urandom;
      end
      if (!m_pend && $urandom_range(0, 99) < 40) begin
        m_pend = 1'b1; m_a = 5'($urandom_range(0, 31)); m_d = $urandom;
      end
    end
    rst = do_rst;
    p_valid = p_pend; p_waddr = p_a; p_wdata = p_d;
    m_valid = m_pend; m_waddr = m_a; m_wdata = m_d;

    starved = FAIR && m_pend && (m_wait >= LIM);
    if (do_rst) begin
      pr = 1'b0; mr = 1'b0;
    end else if (starved) begin
      pr = 1'b0; mr = 1'b1;
    end else begin
      pr = 1'b1; mr = !p_pend;
    end
    p_win = pr && p_pend;
    m_win = !p_win && mr && m_pend;
    last_m_win = m_win;

    #1;
    checkOutput("p_ready", 32'(p_ready), 32'(pr));
    checkOutput("m_ready", 32'(m_ready), 32'(mr));

    if (p_win) begin
      sb.push_back('{due: cyc + 1, we: (p_a != 0), addr: p_a, data: p_d, gnt: 2'd1});
      p_pend = 1'b0;
      if (p_keep) begin
        p_pend = 1'b1; p_a = 5'($urandom_range(1, 31)); p_d = $urandom;
      end
    end
    if (m_win) begin
      sb.push_back('{due: cyc + 1, we: (m_a != 0), addr: m_a, data: m_d, gnt: 2'd2});
      m_pend = 1'b0;
    end

    if (do_rst || !m_pend) m_wait = 0;
    else m_wait = (m_wait + 1 > 15) ? 15 : m_wait + 1;
  endtask

  task automatic drainAll();
    for (int i = 0; i < 40 && (p_pend || m_pend); i++) applyStimulus(1'b0);
    checkOutput("drain_timeout", {30'd0, p_pend, m_pend}, 32'd0);
  endtask

  // Monitor: pops an expectation whenever the DUT shows a grant or write pulse
  always @(negedge clk) begin
    if (mon_en) begin
      if (gnt != 2'd0 || we) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_gnt", {30'd0, gnt}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("latency", cyc, e.due);
          checkOutput("gnt", {30'd0, gnt}, {30'd0, e.gnt});
          checkOutput("we", {31'd0, we}, {31'd0, e.we});
          if (e.we) begin
            checkOutput("waddr", {27'd0, waddr}, {27'd0, e.addr});
            checkOutput("wdata", wdata, e.data);
          end
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        checkOutput("missing_write", cyc, 32'(sb[0].due - 1));
        void'(sb.pop_front());
      end else begin
        checkOutput("idle_we", {31'd0, we}, 32'd0);
      end
    end
  end

  initial begin
    int m_first;
    rst = 1'b1;
    p_valid = 1'b0; m_valid = 1'b0;
    p_waddr = '0; m_waddr = '0; p_wdata = '0; m_wdata = '0;

    // Reset held 3 cycles with both requesters valid
    p_pend = 1'b1; p_a = 5'd7; p_d = 32'hCAFE_0007;
    m_pend = 1'b1; m_a = 5'd9; m_d = 32'hBEEF_0009;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      mon_en = 1'b1;
    end
    drainAll();

    // Single P write
    p_pend = 1'b1; p_a = 5'd5; p_d = 32'h1234_5678;
    drainAll();
    applyStimulus(1'b0);

    // Contention on the same address
    p_pend = 1'b1; p_a = 5'd3; p_d = 32'h0000_000A;
    m_pend = 1'b1; m_a = 5'd3; m_d = 32'h0000_000B;
    drainAll();

    // Write to $0 is consumed
    m_pend = 1'b1; m_a = 5'd0; m_d = 32'hFFFF_FFFF;
    drainAll();
    applyStimulus(1'b0);

    // Starvation window: P always valid
    p_keep = 1'b1;
    p_pend = 1'b1; p_a = 5'd4; p_d = 32'h4444_0000;
    m_pend = 1'b1; m_a = 5'd20; m_d = 32'h2020_2020;
    m_first = 0;
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(1'b0);
      if (last_m_win && m_first == 0) m_first = i;
    end
    checkOutput("starve_m_slot", m_first, FAIR ? 32'd5 : 32'd0);
    p_keep = 1'b0;
    drainAll();

    // Reset arriving while a write is pending / registered
    p_pend = 1'b1; p_a = 5'd12; p_d = 32'h0C0C_0C0C;
    applyStimulus(1'b0);
    p_pend = 1'b1; p_a = 5'd13; p_d = 32'h0D0D_0D0D;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    drainAll();

    // Random traffic
    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) applyStimulus(1'b0);
    rand_en = 1'b0;
    drainAll();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0);
    checkOutput("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
